shift_serializer: RTL and testbench
===================================

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 Parameter: WIDTH, default 4, word length in bits (WIDTH >= 2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_data  in  WIDTH  parallel word to serialize.
REQ-005 in_valid  in  1  in_data is valid this cycle.
REQ-006 in_ready  out  1  block accepts in_data this cycle.
REQ-007 dir  in  1  shift order, sampled only at load: 0 = MSB first (left shift), 1 = LSB first (right shift).
REQ-008 hold  in  1  freeze shifting; register, counter and state unchanged.
REQ-009 ser_out  out  1  current serial bit.
REQ-010 ser_valid  out  1  ser_out is valid and is consumed at the next rising edge.
REQ-011 last  out  1  ser_out is the final bit of the current word.
REQ-012 busy  out  1  a word is being serialized.

Function
REQ-013 The block SHALL hold an internal WIDTH-bit shift register, a latched dir bit, and a bit counter of width clog2(WIDTH).
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 A load SHALL occur on any rising edge where in_valid=1 and in_ready=1.
REQ-016 On a load, the block SHALL perform all of the following: shift register <= in_data, latched dir <= dir, counter <= WIDTH-1, state <= SHIFT.
REQ-017 in_ready SHALL be the following combinational function of registered state: in_ready = (state==IDLE) OR (state==SHIFT AND counter==0 AND hold==0).
REQ-018 While reset is asserted, in_ready SHALL be 0.
REQ-019 In SHIFT, ser_out SHALL be shift register[WIDTH-1] when latched dir=0, and shift register[0] when latched dir=1.
REQ-020 In IDLE, ser_out SHALL be 0.
REQ-021 ser_valid SHALL equal (state==SHIFT AND hold==0).
REQ-022 last SHALL equal (ser_valid AND counter==0).
REQ-023 busy SHALL equal (state==SHIFT).
REQ-024 In SHIFT with hold=0 and counter>0, each edge SHALL perform both of the following:
- shift the register one position (toward MSB if dir=0, toward LSB if dir=1), filling 0;
- decrement the counter.
REQ-025 In SHIFT with hold=0 and counter==0, if a load occurs the block SHALL stay in SHIFT with the new word (back-to-back, no gap cycle); otherwise it SHALL go to IDLE.
REQ-026 In SHIFT with hold=1, all state SHALL be unchanged, ser_valid=0 and in_ready=0.
REQ-027 hold SHALL have no effect in IDLE.
REQ-028 in_valid while in_ready=0 SHALL be ignored.
REQ-029 dir changes after a load SHALL not affect the word in flight.
REQ-030 Serialization latency: the first bit SHALL be valid in the cycle after the load edge, and a word SHALL occupy exactly WIDTH ser_valid cycles, excluding hold cycles.

Reset
REQ-031 Asserting reset (reset=0) SHALL immediately, without waiting for a clock edge, set: state=IDLE, shift register=0, counter=0, latched dir=0.
REQ-032 The resulting outputs SHALL be ser_out=0, ser_valid=0, last=0, busy=0, in_ready=0.
REQ-033 Reset asserted mid-word SHALL discard the partial word; no further bits of that word SHALL be emitted.
REQ-034 After reset deasserts, in_ready SHALL be 1 and the first load SHALL be accepted on the next rising edge with in_valid=1.

Verification (WIDTH=4)
REQ-035 MSB-first: load 1101 with dir=0, hold=0 -> the next 4 cycles give ser_out 1,1,0,1 with ser_valid=1; last=1 only on the 4th cycle; then busy=0.
REQ-036 LSB-first: load 1101 with dir=1 -> ser_out 1,0,1,1; last on the 4th bit.
REQ-037 Hold: load 1010 with dir=0, then hold=1 for 2 cycles after the 2nd bit -> ser_valid=0 and ser_out stays 1 during hold; then bits 1,0 resume; last on the final bit.
REQ-038 Back-to-back: in_valid held at 1 with 1100 then 0011, dir=0 -> 8 consecutive ser_valid cycles 1,1,0,0,0,0,1,1; in_ready=1 only during the last-bit cycle of the first word.
REQ-039 Busy ignore: present 1111 with in_valid=1 during bits 1-3 of word 1001 -> output remains 1,0,0,1; 1111 is accepted only at the last-bit cycle.
REQ-040 Reset mid-word: reset=0 after the 2nd bit of 1101 -> all outputs 0 immediately; after release, load 0110 with dir=0 -> ser_out 0,1,1,0.

Source files
------------

// File: rtl/shift_serializer.sv
// Parallel-to-serial converter with valid/ready load and hold.
// Ports: clk, reset (async low), in_data/in_valid/in_ready, dir, hold,
//        ser_out, ser_valid, last, busy.
module shift_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             dir,
   input  logic             hold,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sreg;
   logic [CW-1:0]    r_cnt;
   logic             r_dir;

   state_t           w_nxt_state;
   logic [WIDTH-1:0] w_nxt_sreg;
   logic [CW-1:0]    w_nxt_cnt;
   logic             w_nxt_dir;
   logic             w_load;
   logic             w_cnt_zero;
   logic             w_shift;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_shift    = (r_state == S_SHIFT);

   // Ready is masked while reset is held so nothing is loaded then.
   assign in_ready  = reset & (!w_shift | (w_cnt_zero & !hold));
   assign w_load    = in_valid & in_ready;

   assign ser_valid = w_shift & !hold;
   assign last      = ser_valid & w_cnt_zero;
   assign busy      = w_shift;
   assign ser_out   = !w_shift ? 1'b0 :
                      (r_dir ? r_sreg[0] : r_sreg[WIDTH-1]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_sreg  <= '0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_sreg  <= w_nxt_sreg;
         r_cnt   <= w_nxt_cnt;
         r_dir   <= w_nxt_dir;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sreg  = r_sreg;
      w_nxt_cnt   = r_cnt;
      w_nxt_dir   = r_dir;
      unique case (r_state)
         S_IDLE: begin
            if (w_load) begin
               w_nxt_state = S_SHIFT;
               w_nxt_sreg  = in_data;
               w_nxt_cnt   = CNT_TOP;
               w_nxt_dir   = dir;
            end
         end
         S_SHIFT: begin
            if (!hold) begin
               if (!w_cnt_zero) begin
                  w_nxt_sreg = r_dir ? (r_sreg >> 1) : (r_sreg << 1);
                  w_nxt_cnt  = r_cnt - 1'b1;
               end else if (w_load) begin
                  // Back-to-back word: reload without an idle gap.
                  w_nxt_sreg = in_data;
                  w_nxt_cnt  = CNT_TOP;
                  w_nxt_dir  = dir;
               end else begin
                  w_nxt_state = S_IDLE;
               end
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer at WIDTH=4.
// Expected bit streams are hand-computed constants.
module tb_shift_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       dir;
   logic       hold;
   logic       ser_out;
   logic       ser_valid;
   logic       last;
   logic       busy;

   int n_tot = 0;
   int n_bad = 0;

   shift_serializer #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dir       (dir),
      .hold      (hold),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .last      (last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic so,
                          input logic sv, input logic la,
                          input logic bz, input logic rd);
      #1;
      check({tag, ".so"}, 32'(ser_out), 32'(so));
      check({tag, ".sv"}, 32'(ser_valid), 32'(sv));
      check({tag, ".last"}, 32'(last), 32'(la));
      check({tag, ".busy"}, 32'(busy), 32'(bz));
      check({tag, ".rdy"}, 32'(in_ready), 32'(rd));
   endtask

   // exp[3] is the first expected serial bit.
   task automatic run_word(input string tag, input logic [3:0] data,
                           input logic d, input logic [3:0] exp);
      in_data  = data;
      dir      = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      dir      = ~d;
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("%s.b%0d", tag, i), exp[3-i], 1'b1,
                 (i == 3), 1'b1, (i == 3));
         tick();
      end
      chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset    = 1'b0;
      in_data  = 4'b0000;
      in_valid = 1'b0;
      dir      = 1'b0;
      hold     = 1'b0;
      chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      chk_out("rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // hold in IDLE has no effect
      hold = 1'b1;
      chk_out("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      hold = 1'b0;

      run_word("msb", 4'b1101, 1'b0, 4'b1101);
      run_word("lsb", 4'b1101, 1'b1, 4'b1011);

      // hold for two cycles before the third bit
      in_data  = 4'b1010;
      dir      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_out("hld.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("hld.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      hold = 1'b1;
      chk_out("hld.h0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("hld.h1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      hold = 1'b0;
      chk_out("hld.b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("hld.b3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      chk_out("hld.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // back-to-back 1100 then 0011
      in_data  = 4'b1100;
      dir      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_data = 4'b0011;
      chk_out("b2b.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("b2b.b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("b2b.b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("b2b.b3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      chk_out("b2b.b4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("b2b.b5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("b2b.b6", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("b2b.b7", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      chk_out("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 1111 offered while 1001 is in flight
      in_data  = 4'b1001;
      dir      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_data = 4'b1111;
      chk_out("bsy.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("bsy.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("bsy.b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("bsy.b3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("bsy.w2b%0d", i), 1'b1, 1'b1,
                 (i == 3), 1'b1, (i == 3));
         tick();
      end
      chk_out("bsy.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // reset in the middle of 1101
      in_data  = 4'b1101;
      dir      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_out("mid.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("mid.b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      #1;
      reset = 1'b0;
      chk_out("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mid.rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      chk_out("mid.rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_word("mid.new", 4'b0110, 1'b0, 4'b0110);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
